// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch unit between the PC register and a byte-wide unified RAM.
// A 32-bit little-endian instruction is assembled from four sequential byte
// reads (RAM returns data one cycle after the address) and presented to the
// IF/ID register as a one-cycle inst_valid_o pulse. stall_o holds the core
// while a fetch is outstanding.
//
// Optional feature, macro ICACHE_EN: a direct-mapped, one-word-per-line
// instruction cache with ICACHE_LINES entries that returns hits in one cycle.
// Without the macro, no cache storage exists and every fetch takes the
// six-cycle miss path.
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int ADDR_WIDTH   = 32,
    parameter int ICACHE_LINES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    output logic [31:0]           inst_o,
    output logic                  inst_valid_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    input  logic [7:0]            mem_din_i,
    output logic                  mem_wr_o
);

    // RD0..RD2 issue addresses wa+1..wa+3; RD1..WAIT capture bytes 0..3,
    // each arriving one cycle after its address was presented.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HIT  = 3'd1,
        S_RD0  = 3'd2,
        S_RD1  = 3'd3,
        S_RD2  = 3'd4,
        S_RD3  = 3'd5,
        S_WAIT = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_wa;        // word address latched on acceptance
    logic [ADDR_WIDTH-1:0] r_mem_a;
    logic [31:0]           r_inst;
    logic [7:0]            r_b0;
    logic [7:0]            r_b1;
    logic [7:0]            r_b2;

    logic [ADDR_WIDTH-1:0] w_wa;        // word-aligned view of pc_i
    logic                  w_accept;    // request taken in IDLE this cycle
    logic                  w_fill;      // completed miss writes the cache
    logic                  w_hit;       // pc_i hits a valid cache line
    logic [31:0]           w_hit_word;
    logic                  w_valid_q;   // DONE/HIT: a result is on inst_o
    logic                  w_unused;

    assign w_wa = {pc_i[ADDR_WIDTH-1:2], 2'b00};

    // State register; synchronous reset aborts any fetch in flight.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus the accept/fill strobes; flush overrides all.
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A flush in the same cycle defers acceptance to the next one.
                if (req_i && !flush_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_hit ? S_HIT : S_RD0;
                end
            end
            S_HIT:  w_state_nxt = S_IDLE;
            S_RD0:  w_state_nxt = S_RD1;
            S_RD1:  w_state_nxt = S_RD2;
            S_RD2:  w_state_nxt = S_RD3;
            S_RD3:  w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_DONE;
            S_DONE: begin
                w_fill      = !flush_i;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Address sequencing, byte capture and instruction assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wa    <= '0;
            r_mem_a <= '0;
            r_inst  <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_b2    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wa <= w_wa;
                        if (w_hit) begin
                            r_inst <= w_hit_word;
                        end else begin
                            r_mem_a <= w_wa;
                        end
                    end
                end
                // Increments wrap modulo 2^ADDR_WIDTH by construction.
                S_RD0: r_mem_a <= r_wa + ADDR_WIDTH'(1);
                S_RD1: begin
                    r_mem_a <= r_wa + ADDR_WIDTH'(2);
                    r_b0    <= mem_din_i;
                end
                S_RD2: begin
                    r_mem_a <= r_wa + ADDR_WIDTH'(3);
                    r_b1    <= mem_din_i;
                end
                S_RD3: r_b2 <= mem_din_i;
                S_WAIT: begin
                    // A flushed fetch leaves the previous instruction untouched.
                    if (!flush_i) begin
                        r_inst <= {mem_din_i, r_b2, r_b1, r_b0};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ICACHE_EN
    localparam int INDEX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W   = ADDR_WIDTH - 2 - INDEX_W;

    logic [31:0]             r_line_data [ICACHE_LINES];
    logic [TAG_W-1:0]        r_line_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] r_line_valid;

    logic [INDEX_W-1:0]      w_rd_index;
    logic [TAG_W-1:0]        w_rd_tag;
    logic [INDEX_W-1:0]      w_wr_index;
    logic [TAG_W-1:0]        w_wr_tag;

    // Lookup uses the live pc_i; the fill uses the address latched at accept.
    assign w_rd_index = w_wa[INDEX_W+1:2];
    assign w_rd_tag   = w_wa[ADDR_WIDTH-1:INDEX_W+2];
    assign w_wr_index = r_wa[INDEX_W+1:2];
    assign w_wr_tag   = r_wa[ADDR_WIDTH-1:INDEX_W+2];

    assign w_hit      = r_line_valid[w_rd_index] && (r_line_tag[w_rd_index] == w_rd_tag);
    assign w_hit_word = r_line_data[w_rd_index];

    // Line valid bits: cleared by reset, set when a miss completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_valid <= '0;
        end else if (w_fill) begin
            r_line_valid[w_wr_index] <= 1'b1;
        end
    end

    // Line data and tag; a completed miss overwrites any conflicting line.
    // NOTE: the storage arrays are deliberately not reset; the valid bits
    // alone decide whether a line's contents may be used.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_line_data[w_wr_index] <= r_inst;
            r_line_tag[w_wr_index]  <= w_wr_tag;
        end
    end

    assign w_unused = ^pc_i[1:0];
`else
    assign w_hit      = 1'b0;
    assign w_hit_word = '0;
    assign w_unused   = ^{pc_i[1:0], w_fill, ICACHE_LINES[0]};
`endif

    assign w_valid_q    = (r_state == S_DONE) || (r_state == S_HIT);
    assign inst_valid_o = w_valid_q & ~flush_i;
    assign inst_o       = r_inst;
    assign stall_o      = req_i & ~inst_valid_o;
    assign mem_a_o      = r_mem_a;
    assign mem_wr_o     = 1'b0;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Self-checking bench for inst_fetch. A byte RAM model answers mem_a_o one
// cycle later; a reference model predicts each fetch's word from the RAM
// contents and its latency from an abstract direct-mapped cache (only when
// ICACHE_EN is defined). Inputs change 1 time unit after posedge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int AW    = 32;
    localparam int LINES = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i;
    logic [AW-1:0] pc_i;
    logic          flush_i;
    logic [31:0]   inst_o;
    logic          inst_valid_o;
    logic          stall_o;
    logic [AW-1:0] mem_a_o;
    logic [7:0]    mem_din_i = '0;
    logic          mem_wr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch #(
        .ADDR_WIDTH  (AW),
        .ICACHE_LINES(LINES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .pc_i        (pc_i),
        .flush_i     (flush_i),
        .inst_o      (inst_o),
        .inst_valid_o(inst_valid_o),
        .stall_o     (stall_o),
        .mem_a_o     (mem_a_o),
        .mem_din_i   (mem_din_i),
        .mem_wr_o    (mem_wr_o)
    );

    // ---------------- RAM model: sparse bytes, one-cycle read latency -------
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[31:24] ^ 8'h3C;
    endfunction

    always @(posedge clk) mem_din_i <= ram_byte(mem_a_o);

    // ---------------- Reference model ---------------------------------------
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];

    function automatic logic [31:0] word_at(input logic [31:0] wa);
        return {ram_byte(wa + 32'd3), ram_byte(wa + 32'd2),
                ram_byte(wa + 32'd1), ram_byte(wa)};
    endfunction

    function automatic bit model_hit(input logic [31:0] wa);
`ifdef ICACHE_EN
        int idx;
        idx = int'((wa / 4) % LINES);
        return m_valid[idx] && (m_tag[idx] == wa / (4 * LINES));
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_fill(input logic [31:0] wa);
        int idx;
        idx = int'((wa / 4) % LINES);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = wa / (4 * LINES);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    // ---------------- Helpers ----------------------------------------------
    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full fetch from acceptance to the valid pulse. Called 1 unit after a
    // posedge with the DUT idle; returns 1 unit after the posedge following
    // the valid cycle with req_i dropped.
    task automatic fetch(input logic [31:0] pc);
        logic [31:0] wa;
        logic [31:0] exp_word;
        bit          hit;
        int          lat;
        wa       = {pc[31:2], 2'b00};
        hit      = model_hit(wa);
        lat      = hit ? 1 : 6;
        exp_word = word_at(wa);
        req_i    = 1'b1;
        pc_i     = pc;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            check("valid", {31'd0, inst_valid_o}, {31'd0, c == lat});
            check("stall", {31'd0, stall_o}, {31'd0, c < lat});
            if (!hit && c >= 1 && c <= 4) check("mem_a", mem_a_o, wa + 32'(c - 1));
            if (c == lat) begin
                check("inst", inst_o, exp_word);
                check("mem_wr", {31'd0, mem_wr_o}, 32'd0);
            end
            next_cycle();
        end
        req_i = 1'b0;
        if (!hit) model_fill(wa);
    endtask

    // ---------------- Stimulus ----------------------------------------------
    initial begin
        rst     = 1'b1;
        req_i   = 1'b0;
        pc_i    = '0;
        flush_i = 1'b0;
        model_reset();
        for (int a = 0; a < 2048; a++) ram[a] = 8'($urandom);
        ram[4] = 8'h13;
        ram[5] = 8'h05;
        ram[6] = 8'hA0;
        ram[7] = 8'h00;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_inst", inst_o, 32'd0);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_mem_a", mem_a_o, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        next_cycle();

        // Basic miss from 0x4, then misaligned pc resolving to the same word
        fetch(32'h0000_0004);
        fetch(32'h0000_0007);

        // Address wrap at the top of the address space
        fetch(32'hFFFF_FFFC);

        // Flush at T+3 of a fetch from 0x10, then a request for 0x20
        req_i = 1'b1;
        pc_i  = 32'h0000_0010;
        for (int c = 0; c <= 3; c++) begin
            if (c == 3) flush_i = 1'b1;
            @(negedge clk);
            check("flush_valid", {31'd0, inst_valid_o}, 32'd0);
            check("flush_stall", {31'd0, stall_o}, 32'd1);
            next_cycle();
        end
        flush_i = 1'b0;
        fetch(32'h0000_0020);
        fetch(32'h0000_0010);

        // Flush together with a request in IDLE: accepted only a cycle later
        req_i   = 1'b1;
        pc_i    = 32'h0000_0100;
        flush_i = 1'b1;
        @(negedge clk);
        check("idle_flush_valid", {31'd0, inst_valid_o}, 32'd0);
        check("idle_flush_stall", {31'd0, stall_o}, 32'd1);
        next_cycle();
        flush_i = 1'b0;
        fetch(32'h0000_0030);

        // Cache behaviour: repeat, then a conflicting line, then the original
        fetch(32'h0000_0040);
        fetch(32'h0000_0040);
        fetch(32'h0000_0040 + 32'(4 * LINES));
        fetch(32'h0000_0040);

        // Reset at T+4 of a miss after 0x80 has been filled
        fetch(32'h0000_0080);
        req_i = 1'b1;
        pc_i  = 32'h0000_0084;
        for (int c = 0; c <= 4; c++) begin
            if (c == 4) rst = 1'b1;
            @(negedge clk);
            check("pre_rst_valid", {31'd0, inst_valid_o}, 32'd0);
            next_cycle();
        end
        rst   = 1'b0;
        req_i = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_inst", inst_o, 32'd0);
        check("mid_rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("mid_rst_mem_a", mem_a_o, 32'd0);
        check("mid_rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
        next_cycle();
        fetch(32'h0000_0084);
        fetch(32'h0000_0080);

        // Randomized fetches over a small pool with conflicts and idle gaps
        for (int n = 0; n < 40; n++) begin
            logic [31:0] pc;
            pc = 32'($urandom_range(0, 15)) * 32'd4
               + 32'($urandom_range(0, 2)) * 32'(4 * LINES)
               + 32'($urandom_range(0, 3));
            fetch(pc);
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit between the PC register and the byte-wide unified RAM. It assembles 32-bit little-endian instructions from four sequential byte reads and returns them to the IF/ID register. It holds the core with `stall_o` while a fetch is outstanding. An optional direct-mapped instruction cache gives single-cycle hits.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `pc_i` and `mem_a_o`.
- `ICACHE_LINES`, 64: cache entries, one word each; power of two. Used only when the cache is compiled in.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `req_i` input 1: fetch request; held high with `pc_i` stable until `inst_valid_o`.
- `pc_i` input ADDR_WIDTH: fetch address; bits [1:0] ignored (word-aligned).
- `flush_i` input 1: branch taken; abandon the in-flight fetch.
- `inst_o` output 32: fetched instruction.
- `inst_valid_o` output 1: `inst_o` valid; one-cycle pulse per completed fetch.
- `stall_o` output 1: combinational, `req_i & ~inst_valid_o`.
- `mem_a_o` output ADDR_WIDTH: RAM byte address (registered).
- `mem_din_i` input 8: RAM read data, one cycle after address.
- `mem_wr_o` output 1: RAM write enable; constant 0.

## Operation
- Word address `wa = {pc_i[ADDR_WIDTH-1:2], 2'b00}` is latched on acceptance.
- FSM states:
  - `IDLE`: on `req_i & ~flush_i`: cache hit → `HIT`; otherwise → `RD0`, `mem_a_o <= wa`.
  - `HIT`: `inst_o <=` cache word, `inst_valid_o` high; → `IDLE`.
  - `RD0`..`RD2`: `mem_a_o <= wa+1..wa+3`; capture the byte returned for the previous address.
  - `RD3`: capture byte 2; → `WAIT`.
  - `WAIT`: capture byte 3; → `DONE`.
  - `DONE`: `inst_o = {b3,b2,b1,b0}`, `inst_valid_o` high, cache entry written; → `IDLE`.
- Byte `k` comes from address `wa+k` and lands in `inst_o[8k+7:8k]`.
- Address increment wraps modulo 2^ADDR_WIDTH; no carry is propagated beyond ADDR_WIDTH.
- `flush_i` in any non-IDLE state: next state `IDLE`, partial bytes discarded, no cache write. Bytes still returning from the RAM are ignored.
- `inst_valid_o` is gated: the output is `valid_q & ~flush_i`.
- `flush_i` together with a new `req_i` in `IDLE`: the request is not accepted this cycle. It is accepted the next cycle with the new `pc_i`.
- Outputs after reset: `inst_o=0`, `inst_valid_o=0`, `mem_a_o=0`, `mem_wr_o=0`, state `IDLE`. Reset mid-fetch aborts identically.

## Timing
- Requests are accepted in cycle T (state `IDLE`, `req_i` high).
- Miss: `mem_a_o` shows `wa`..`wa+3` in T+1..T+4. Bytes are on `mem_din_i` in T+2..T+5. `inst_valid_o` is high in T+6. `stall_o` is high in T..T+5.
- Hit: `inst_valid_o` is high in T+1; `stall_o` is high in T only.
- Back-to-back: the next request can be accepted in the cycle after `inst_valid_o`.
- No combinational path from `mem_din_i` to any output.

## Configuration
- Macro: `ICACHE_EN`.
- Defined: direct-mapped cache with `ICACHE_LINES` words.
  - Index is `wa[log2(ICACHE_LINES)+1:2]`; tag is the remaining upper bits; there is a valid bit per line.
  - All valid bits are cleared by `rst`.
  - A completed miss (`DONE`) fills the line and overwrites on conflict.
- Undefined: no storage is instantiated and state `HIT` is unreachable. Every fetch takes the 6-cycle miss path.

## Test plan
- Reset, then a fetch with `pc_i=0x0000_0004` and RAM[4..7] = `13,05,A0,00`: required `inst_o=0x00A0_0513` with `inst_valid_o` at T+6; `mem_a_o` sequence 4,5,6,7; `stall_o` high for 6 cycles.
- Misaligned `pc_i=0x0000_0007`: bytes are fetched from 4..7; result identical to the case above.
- `flush_i` pulsed at T+3 of a fetch from 0x10, then a request for 0x20: no `inst_valid_o` for 0x10; the fetch from 0x20 completes correctly; with `ICACHE_EN`, a later fetch from 0x10 still misses (6 cycles).
- `ICACHE_EN`, fetch 0x40 twice: the first completes in 6 cycles, the second asserts `inst_valid_o` at T+1 with the same word. Then fetch `0x40 + 4*ICACHE_LINES` (conflict) followed by 0x40: both miss.
- `rst` asserted at T+4 of a miss: next cycle all outputs are at reset values and the state is `IDLE`; a subsequent fetch of the same pc takes the miss path (cache invalidated).
- Address wrap, `pc_i=0xFFFF_FFFC`: `mem_a_o` sequence FC,FD,FE,FF (upper bits 1s); no overflow into other bits.
